// File: rtl/gtxe2_chnl_pkg.sv
// gtxe2_chnl_pkg: shared GTXE2 channel constants, comma patterns and RX alignment state
package gtxe2_chnl_pkg;
  localparam logic [9:0] PCOMMA_K285 = 10'b0101111100;
  localparam logic [9:0] MCOMMA_K285 = 10'b1010000011;
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} rx_state_e;
  function automatic int trimmed_width(input int w);
    return w * 4 / 5;
  endfunction
endpackage

// File: rtl/gtxe2_chnl_rx_comma_det.sv
// gtxe2_chnl_rx_comma_det: masked compare of a 10-bit window against both comma polarities
module gtxe2_chnl_rx_comma_det
  import gtxe2_chnl_pkg::*;
#(
  parameter logic [9:0] pcomma     = PCOMMA_K285,
  parameter logic [9:0] mcomma     = MCOMMA_K285,
  parameter logic [9:0] comma_mask = 10'h3ff
) (
  input  logic [9:0] win,
  output logic       hit
);
  assign hit = (((win ^ pcomma) & comma_mask) == 10'd0) || (((win ^ mcomma) & comma_mask) == 10'd0);
endmodule

// File: rtl/gtxe2_chnl_rx_des.sv
// gtxe2_chnl_rx_des: LSB-first serial to word deserializer with comma alignment and idle flag
module gtxe2_chnl_rx_des
  import gtxe2_chnl_pkg::*;
#(
  parameter int         width      = 20,
  parameter logic [9:0] pcomma     = PCOMMA_K285,
  parameter logic [9:0] mcomma     = MCOMMA_K285,
  parameter logic [9:0] comma_mask = 10'h3ff
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             trim,
  input  logic             align_en,
  input  logic             indata,
  input  logic             idle_in,
  output logic [width-1:0] outdata,
  output logic             outvalid,
  output logic             idle_out,
  output logic             comma_det,
  output logic             realign,
  output logic             aligned
);
  localparam int tw = trimmed_width(width);
  localparam int cw = $clog2(width);
  rx_state_e state;
  logic trim_r, idle_acc, hit, word_hit, wrap, move, idle_nx;
  logic [cw-1:0] bitcounter, last;
  logic [width-1:0] sr, sr_n, keep;
  logic [9:0] win;
  assign last = trim_r ? cw'(tw - 1) : cw'(width - 1);
  assign keep = (width'(1) << last) - width'(1);
  assign sr_n = ((sr >> 1) & keep) | (width'(indata) << last);
  assign win = 10'(sr_n >> (last - cw'(9)));
  assign wrap = bitcounter == last;
  assign move = hit && align_en && bitcounter != cw'(9);
  assign idle_nx = (bitcounter == '0 || idle_acc) && idle_in;
  assign aligned = state == LOCKED;
  gtxe2_chnl_rx_comma_det #(.pcomma(pcomma), .mcomma(mcomma), .comma_mask(comma_mask)) u_win_det (
    .win(win),
    .hit(hit)
  );
  gtxe2_chnl_rx_comma_det #(.pcomma(pcomma), .mcomma(mcomma), .comma_mask(comma_mask)) u_word_det (
    .win(sr_n[9:0]),
    .hit(word_hit)
  );
  // shift bits in, emit words at the wrap, and move the boundary onto an off-position comma
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      idle_acc   <= 1'b0;
      bitcounter <= '0;
      trim_r     <= 1'b0;
      state      <= SEARCH;
      outdata    <= '0;
      outvalid   <= 1'b0;
      idle_out   <= 1'b0;
      comma_det  <= 1'b0;
      realign    <= 1'b0;
    end else begin
      sr       <= sr_n;
      idle_acc <= idle_nx;
      outvalid <= 1'b0;
      realign  <= 1'b0;
      if (move) begin
        bitcounter <= cw'(10);
        realign    <= 1'b1;
        state      <= SEARCH;
      end else if (wrap) begin
        bitcounter <= '0;
        outdata    <= sr_n;
        outvalid   <= 1'b1;
        idle_out   <= idle_nx;
        comma_det  <= word_hit;
        trim_r     <= trim;
        state      <= (idle_nx || trim != trim_r) ? SEARCH : word_hit ? LOCKED : state;
      end else begin
        bitcounter <= bitcounter + cw'(1);
      end
    end
  end
endmodule

// File: tb/tb_gtxe2_chnl_rx_des.sv
// tb_gtxe2_chnl_rx_des: directed and random serial streams checked against a queue-based word model
module tb_gtxe2_chnl_rx_des;
  logic inclk = 1'b0, reset = 1'b0, trim = 1'b0, align_en = 1'b1, indata = 1'b0, idle_in = 1'b0;
  logic [19:0] outdata;
  logic outvalid, idle_out, comma_det, realign, aligned;
  int vectors = 0, errors = 0;
  int since = 0, last_gap = 0, rcnt = 0;
  logic m_q[$];
  logic m_iq[$];
  int m_pos;
  logic m_lock, m_trim;
  logic [19:0] e_out;
  logic e_ov, e_idle, e_cd, e_ra;

  gtxe2_chnl_rx_des dut (
    .inclk(inclk), .reset(reset), .trim(trim), .align_en(align_en), .indata(indata), .idle_in(idle_in),
    .outdata(outdata), .outvalid(outvalid), .idle_out(idle_out), .comma_det(comma_det),
    .realign(realign), .aligned(aligned)
  );

  always #5 inclk = ~inclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_comma(input logic [9:0] w);
    return w == 10'b0101111100 || w == 10'b1010000011;
  endfunction

  function automatic void m_reset();
    m_q = {};
    repeat (20) m_q.push_back(1'b0);
    m_iq = {};
    m_pos = 0; m_lock = 0; m_trim = 0;
    e_out = '0; e_ov = 0; e_idle = 0; e_cd = 0; e_ra = 0;
  endfunction

  // word model: the receive window is the last n bits, oldest first
  function automatic void m_step(input logic d, input logic idl);
    int n = m_trim ? 16 : 20;
    logic [19:0] w = '0;
    logic [9:0] win;
    void'(m_q.pop_front());
    while (m_q.size() > n - 1) void'(m_q.pop_back());
    while (m_q.size() < n - 1) m_q.push_back(1'b0);
    m_q.push_back(d);
    m_iq.push_back(idl);
    for (int i = 0; i < n; i++) w[i] = m_q[i];
    for (int i = 0; i < 10; i++) win[i] = m_q[n - 10 + i];
    e_ov = 0; e_ra = 0;
    if (is_comma(win) && align_en && m_pos != 9) begin
      m_pos = 10; e_ra = 1; m_lock = 0;
    end else if (m_pos == n - 1) begin
      e_ov = 1; e_out = w; e_cd = is_comma(w[9:0]);
      e_idle = 1;
      foreach (m_iq[i]) if (!m_iq[i]) e_idle = 0;
      if (e_idle || trim != m_trim) m_lock = 0;
      else if (e_cd) m_lock = 1;
      m_trim = trim; m_pos = 0; m_iq = {};
    end else m_pos++;
  endfunction

  task automatic bit_in(input logic d, input logic idl);
    indata = d; idle_in = idl;
    @(posedge inclk);
    m_step(d, idl);
    #1;
    chk("outvalid", outvalid, e_ov);
    chk("realign", realign, e_ra);
    chk("aligned", aligned, m_lock);
    chk("outdata", outdata, e_out);
    chk("idle_out", idle_out, e_idle);
    chk("comma_det", comma_det, e_cd);
    since++;
    if (outvalid) begin last_gap = since; since = 0; end
    rcnt += int'(realign);
  endtask

  task automatic send_word(input logic [19:0] v, input int nb, input logic idl);
    for (int i = 0; i < nb; i++) bit_in(v[i], idl);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1; m_reset(); since = 0;
    #1;
    chk("rst_outdata", outdata, 0);
    chk("rst_outvalid", outvalid, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_realign", realign, 0);
    chk("rst_idle_out", idle_out, 0);
    chk("rst_comma_det", comma_det, 0);
    repeat (cyc) @(posedge inclk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int r0;
    #2 do_reset(2);
    for (int k = 0; k < 2; k++) begin
      send_word(20'h0A5A5, 20, 1'b0);
      chk("t1_valid", outvalid, 1);
      chk("t1_gap", last_gap, 20);
      chk("t1_data", outdata, 20'h0A5A5);
      chk("t1_aligned", aligned, 0);
    end
    r0 = rcnt;
    send_word(20'h5, 3, 1'b0); send_word(20'h17C, 10, 1'b0); send_word(20'h0, 10, 1'b0);
    chk("t2_realign_once", rcnt - r0, 1);
    chk("t2_valid", outvalid, 1);
    chk("t2_low", outdata[9:0], 10'h17C);
    chk("t2_comma", comma_det, 1);
    chk("t2_aligned", aligned, 1);
    send_word(20'h0A5A5, 7, 1'b0);
    do_reset(2);
    send_word(20'h0A5A5, 20, 1'b0);
    chk("t6_valid", outvalid, 1);
    chk("t6_gap", last_gap, 20);
    chk("t6_data", outdata, 20'h0A5A5);
    align_en = 1'b0; r0 = rcnt;
    send_word(20'h5, 3, 1'b0); send_word(20'h17C, 10, 1'b0); send_word(20'h0, 7, 1'b0);
    chk("t3_no_realign", rcnt - r0, 0);
    chk("t3_gap", last_gap, 20);
    chk("t3_low_not_comma", outdata[9:0] != 10'h17C, 1);
    chk("t3_aligned", aligned, 0);
    align_en = 1'b1;
    send_word(20'h5, 3, 1'b0); send_word(20'h17C, 10, 1'b0); send_word(20'h0, 10, 1'b0);
    chk("relock_aligned", aligned, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) trim = 1'b1;
      bit_in(i < 13, 1'b0);
    end
    chk("t4_gap20", last_gap, 20);
    chk("t4_aligned", aligned, 0);
    for (int k = 0; k < 2; k++) begin
      send_word(20'h01FFF, 16, 1'b0);
      chk("t4_gap16", last_gap, 16);
      chk("t4_data", outdata, 20'h01FFF);
    end
    r0 = rcnt;
    send_word(20'h17C, 16, 1'b0);
    chk("t5_inplace", rcnt - r0, 0);
    chk("t5_comma", comma_det, 1);
    chk("t5_locked", aligned, 1);
    send_word(20'h0, 16, 1'b1);
    chk("t5_valid", outvalid, 1);
    chk("t5_idle", idle_out, 1);
    chk("t5_aligned", aligned, 0);
    for (int k = 0; k < 3000; k++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) send_word($urandom_range(0, 1) ? 20'h17C : 20'h283, 10, 1'b0);
      else if (r < 5) send_word(20'h0, 20, 1'b1);
      else bit_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 149) == 0) trim = ~trim;
      if ($urandom_range(0, 99) == 0) align_en = ~align_en;
      if ($urandom_range(0, 999) == 0) do_reset(2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
